// File: rtl/conv_row_sequencer_pkg.sv
// Shared state encoding and FIFO count for the row-stationary stimulus sequencer.
// Pure definitions: no latency, no backpressure.
package conv_row_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_WGT,
        ST_ROW_GAP,
        ST_STREAM,
        ST_ROW_END
    } state_t;

    // One psum FIFO per kernel row; only a 3x3 kernel is supported.
    localparam int FIFO_CNT = 3;

endpackage

// File: rtl/conv_row_sequencer_pos_counter.sv
// Row/column position tracker for the raster-order IFM stream; col wraps at COLS-1.
// Registered, 1-cycle update; no backpressure (advances only on enables).
module conv_row_sequencer_pos_counter #(
    parameter int COLS      = 9,
    parameter int ROWS      = 5,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 col_clr,
    input  logic                 col_inc,
    input  logic                 row_inc,
    output logic [CNT_WIDTH-1:0] row,
    output logic [CNT_WIDTH-1:0] col,
    output logic                 last_col,
    output logic                 last_row
);

    assign last_col = (col == CNT_WIDTH'(COLS - 1));
    assign last_row = (row == CNT_WIDTH'(ROWS - 1));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else begin
            if (col_clr)
                col <= '0;
            else if (col_inc)
                col <= last_col ? '0 : col + 1'b1;
            if (row_inc)
                row <= last_row ? '0 : row + 1'b1;
        end
    end

endmodule

// File: rtl/conv_row_sequencer.sv
// Sequences weight load, raster IFM streaming and psum FIFO strobes for the 3x3 PE array.
// Outputs registered 1 cycle after the accepted beat; ifm_ready is high only while streaming.
module conv_row_sequencer
    import conv_row_sequencer_pkg::*;
#(
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int IFM_COLS     = 9,
    parameter int IFM_ROWS     = 5,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                                        clk1,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt_in,
    input  logic                                        wgt_valid,
    input  logic [IFM_WIDTH-1:0]                        ifm_in,
    input  logic                                        ifm_valid,
    output logic                                        ifm_ready,
    output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt,
    output logic [IFM_WIDTH-1:0]                        ifm,
    output logic                                        set_wgt,
    output logic                                        set_ifm,
    output logic                                        set_reg,
    output logic                                        wr_en_0,
    output logic                                        wr_en_1,
    output logic                                        wr_en_2,
    output logic                                        rd_en_0,
    output logic                                        rd_en_1,
    output logic                                        rd_en_2,
    output logic                                        wr_clr,
    output logic                                        rd_clr,
    output logic                                        busy,
    output logic                                        done
);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   row;
    logic [CNT_WIDTH-1:0]   col;
    logic                   last_col;
    logic                   last_row;
    logic [FIFO_CNT-1:0]    wr_dec;
    logic [FIFO_CNT-1:0]    rd_dec;
    logic [FIFO_CNT-1:0]    wr_en;
    logic [FIFO_CNT-1:0]    rd_en;

    assign ifm_ready = (state == ST_STREAM);

    conv_row_sequencer_pos_counter #(
        .COLS      (IFM_COLS),
        .ROWS      (IFM_ROWS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pos (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .clr      (state == ST_IDLE),
        .col_clr  (state == ST_ROW_GAP),
        .col_inc  ((state == ST_STREAM) && ifm_valid),
        .row_inc  ((state == ST_ROW_END) && !last_row),
        .row      (row),
        .col      (col),
        .last_col (last_col),
        .last_row (last_row)
    );

    // FIFO k starts collecting once kernel row k has data, and is drained from the row after.
    always_comb begin
        wr_dec = '0;
        rd_dec = '0;
        for (int k = 0; k < FIFO_CNT; k++) begin
            wr_dec[k] = (row >= CNT_WIDTH'(k)) && (col >= CNT_WIDTH'(KERNEL_SIZE));
            rd_dec[k] = (row >= CNT_WIDTH'(k + 1)) && (col <= CNT_WIDTH'(IFM_COLS - 2));
        end
    end

    assign wr_en_0 = wr_en[0];
    assign wr_en_1 = wr_en[1];
    assign wr_en_2 = wr_en[2];
    assign rd_en_0 = rd_en[0];
    assign rd_en_1 = rd_en[1];
    assign rd_en_2 = rd_en[2];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wgt     <= '0;
            ifm     <= '0;
            set_wgt <= 1'b0;
            set_ifm <= 1'b0;
            set_reg <= 1'b0;
            wr_en   <= '0;
            rd_en   <= '0;
            wr_clr  <= 1'b0;
            rd_clr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            set_ifm <= 1'b0;
            set_reg <= 1'b0;
            wr_en   <= '0;
            rd_en   <= '0;
            wr_clr  <= 1'b0;
            rd_clr  <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD_WGT;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD_WGT: begin
                    if (wgt_valid) begin
                        wgt     <= wgt_in;
                        set_wgt <= 1'b1;
                        state   <= ST_ROW_GAP;
                    end
                end
                ST_ROW_GAP: begin
                    wr_clr <= 1'b1;
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (ifm_valid) begin
                        ifm     <= ifm_in;
                        set_ifm <= 1'b1;
                        set_reg <= 1'b1;
                        wr_en   <= wr_dec;
                        rd_en   <= rd_dec;
                        if (last_col)
                            state <= ST_ROW_END;
                    end
                end
                ST_ROW_END: begin
                    rd_clr <= 1'b1;
                    if (last_row) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        set_wgt <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state <= ST_ROW_GAP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Randomised bench: a nested-loop run model builds per-cycle stimulus and expected outputs.
// Outputs are compared 1 time unit after every rising edge.
module tb_conv_row_sequencer;

    localparam int COLS = 9;
    localparam int ROWS = 5;

    typedef struct packed {
        logic        set_wgt;
        logic        set_ifm;
        logic        set_reg;
        logic [2:0]  wr;
        logic [2:0]  rd;
        logic        wr_clr;
        logic        rd_clr;
        logic        busy;
        logic        done;
        logic [7:0]  ifm;
        logic [71:0] wgt;
    } obs_t;

    typedef struct {
        logic        start;
        logic        wgt_valid;
        logic        ifm_valid;
        logic [7:0]  px;
        logic [71:0] w;
        logic        ready;
        obs_t        exp;
        int          row;
    } cyc_t;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [71:0] wgt_in = '0;
    logic        wgt_valid = 1'b0;
    logic [7:0]  ifm_in = '0;
    logic        ifm_valid = 1'b0;
    logic        ifm_ready;
    logic [71:0] wgt;
    logic [7:0]  ifm;
    logic        set_wgt, set_ifm, set_reg;
    logic        wr_en_0, wr_en_1, wr_en_2, rd_en_0, rd_en_1, rd_en_2;
    logic        wr_clr, rd_clr, busy, done;

    int   tests = 0;
    int   fails = 0;
    obs_t m;
    cyc_t q[$];
    int   done_at, n_done, n_set_ifm, n_wr_clr, n_rd_clr;
    int   wr_cnt[ROWS][3];
    int   rd_cnt[ROWS][3];

    always #5 clk1 = ~clk1;

    conv_row_sequencer dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .wgt_in(wgt_in), .wgt_valid(wgt_valid),
        .ifm_in(ifm_in), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .wgt(wgt), .ifm(ifm),
        .set_wgt(set_wgt), .set_ifm(set_ifm), .set_reg(set_reg),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .wr_clr(wr_clr), .rd_clr(rd_clr), .busy(busy), .done(done)
    );

    function automatic obs_t actual();
        obs_t a;
        a = {set_wgt, set_ifm, set_reg, {wr_en_2, wr_en_1, wr_en_0}, {rd_en_2, rd_en_1, rd_en_0},
             wr_clr, rd_clr, busy, done, ifm, wgt};
        return a;
    endfunction

    function automatic logic rb();
        return logic'($urandom % 2);
    endfunction

    function automatic logic [71:0] rw();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    function automatic void clr_pulses();
        m.set_ifm = 1'b0; m.set_reg = 1'b0; m.wr = '0; m.rd = '0;
        m.wr_clr = 1'b0; m.rd_clr = 1'b0; m.done = 1'b0;
    endfunction

    task automatic push(input logic s, input logic wv, input logic iv, input logic [7:0] px,
                        input logic [71:0] wi, input logic rdy, input int row);
        cyc_t e;
        e.start = s; e.wgt_valid = wv; e.ifm_valid = iv; e.px = px; e.w = wi;
        e.ready = rdy; e.exp = m; e.row = row;
        q.push_back(e);
    endtask

    // Run model: start, weight wait, then per row gap / beats (with stalls) / end.
    task automatic build_run(input logic [71:0] w, input int wgt_delay, input int st_row,
                             input int st_col, input int st_len, input int stall_pct,
                             input bit rnd_start, input bit noise, input int ab_row, input int ab_col);
        logic s;
        logic [7:0] px;
        int nst;
        q.delete();
        clr_pulses(); m.busy = 1'b1;
        push(1'b1, noise ? rb() : (wgt_delay == 0), noise ? rb() : 1'b1, 8'($urandom), rw(), 1'b0, -1);
        for (int i = 0; i < wgt_delay; i++) begin
            s = rnd_start ? rb() : 1'b0;
            push(s, 1'b0, noise ? rb() : 1'b1, 8'($urandom), rw(), 1'b0, -1);
        end
        clr_pulses(); m.set_wgt = 1'b1; m.wgt = w;
        push(rnd_start ? rb() : 1'b0, 1'b1, noise ? rb() : 1'b1, 8'($urandom), w, 1'b0, -1);
        for (int r = 0; r < ROWS; r++) begin
            clr_pulses(); m.wr_clr = 1'b1;
            push(rnd_start ? rb() : 1'b0, noise ? rb() : 1'b0, noise ? rb() : 1'b1, 8'($urandom), rw(), 1'b0, -1);
            for (int c = 0; c < COLS; c++) begin
                if (r == ab_row && c == ab_col) return;
                nst = (r == st_row && c == st_col) ? st_len :
                      ((stall_pct > 0 && int'($urandom % 100) < stall_pct) ? int'($urandom_range(1, 3)) : 0);
                for (int j = 0; j < nst; j++) begin
                    clr_pulses();
                    push(rnd_start ? rb() : 1'b0, noise ? rb() : 1'b0, 1'b0, 8'($urandom), rw(), 1'b1, -1);
                end
                clr_pulses();
                px = 8'($urandom);
                m.ifm = px; m.set_ifm = 1'b1; m.set_reg = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    m.wr[k] = (r >= k) && (c >= 3);
                    m.rd[k] = (r >= k + 1) && (c <= COLS - 2);
                end
                push(rnd_start ? rb() : 1'b0, noise ? rb() : 1'b0, 1'b1, px, rw(), 1'b1, r);
            end
            clr_pulses(); m.rd_clr = 1'b1;
            if (r == ROWS - 1) begin
                m.busy = 1'b0; m.set_wgt = 1'b0; m.done = 1'b1;
            end
            push(rnd_start ? rb() : 1'b0, noise ? rb() : 1'b0, noise ? rb() : 1'b1, 8'($urandom), rw(), 1'b0, -1);
        end
        clr_pulses();
        push(1'b0, 1'b0, noise ? rb() : 1'b0, 8'($urandom), rw(), 1'b0, -1);
    endtask

    // Applies the queue; entered and left 1 unit after a rising edge.
    task automatic run_queue();
        obs_t a;
        done_at = -1; n_done = 0; n_set_ifm = 0; n_wr_clr = 0; n_rd_clr = 0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 3; k++) begin wr_cnt[r][k] = 0; rd_cnt[r][k] = 0; end
        foreach (q[i]) begin
            start = q[i].start; wgt_valid = q[i].wgt_valid; wgt_in = q[i].w;
            ifm_valid = q[i].ifm_valid; ifm_in = q[i].px;
            tests++;
            if (ifm_ready !== q[i].ready) begin
                fails++;
                $display("FAIL ifm_ready cycle %0d: got %b expected %b", i, ifm_ready, q[i].ready);
            end
            @(posedge clk1); #1;
            a = actual();
            tests++;
            if (a !== q[i].exp) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %h expected %h", i + 1, a, q[i].exp);
            end
            if (set_ifm === 1'b1) n_set_ifm++;
            if (wr_clr === 1'b1) n_wr_clr++;
            if (rd_clr === 1'b1) n_rd_clr++;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = i + 1;
            end
            if (q[i].row >= 0) begin
                wr_cnt[q[i].row][0] += int'(wr_en_0); wr_cnt[q[i].row][1] += int'(wr_en_1);
                wr_cnt[q[i].row][2] += int'(wr_en_2); rd_cnt[q[i].row][0] += int'(rd_en_0);
                rd_cnt[q[i].row][1] += int'(rd_en_1); rd_cnt[q[i].row][2] += int'(rd_en_2);
            end
        end
        start = 1'b0; wgt_valid = 1'b0; ifm_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk1); #1;
        tests++;
        if (actual() !== obs_t'(0) || ifm_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got %h ready %b expected all zero", actual(), ifm_ready);
        end
        rst_n = 1'b1;
        m = '0;
        @(posedge clk1); #1;
    endtask

    task automatic test_full_run();
        logic [71:0] w;
        w = 72'h010203010203010203;
        build_run(w, 0, -1, -1, 0, 0, 1'b0, 1'b0, -1, -1);
        run_queue();
        tests++; if (done_at != 57) begin fails++; $display("FAIL full_done_cycle: got %0d expected 57", done_at); end
        tests++; if (n_set_ifm != 45) begin fails++; $display("FAIL full_set_ifm: got %0d expected 45", n_set_ifm); end
        tests++; if (n_wr_clr != 5) begin fails++; $display("FAIL full_wr_clr: got %0d expected 5", n_wr_clr); end
        tests++; if (n_rd_clr != 5) begin fails++; $display("FAIL full_rd_clr: got %0d expected 5", n_rd_clr); end
        tests++; if (wgt !== w) begin fails++; $display("FAIL full_wgt: got %h expected %h", wgt, w); end
    endtask

    task automatic test_row0();
        build_run(rw(), int'($urandom_range(0, 2)), -1, -1, 0, 0, 1'b1, 1'b1, -1, -1);
        run_queue();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (wr_cnt[0][k] != (k == 0 ? 6 : 0) || rd_cnt[0][k] != 0) begin
                fails++;
                $display("FAIL row0_en k=%0d: wr %0d rd %0d expected wr %0d rd 0", k, wr_cnt[0][k], rd_cnt[0][k], k == 0 ? 6 : 0);
            end
        end
    endtask

    task automatic test_row_rules();
        int ew, er;
        build_run(rw(), 1, -1, -1, 0, 30, 1'b0, 1'b1, -1, -1);
        run_queue();
        for (int r = 1; r < ROWS; r += 2)
            for (int k = 0; k < 3; k++) begin
                ew = (r >= k) ? COLS - 3 : 0;
                er = (r >= k + 1) ? COLS - 1 : 0;
                tests++;
                if (wr_cnt[r][k] != ew || rd_cnt[r][k] != er) begin
                    fails++;
                    $display("FAIL row%0d_en k=%0d: wr %0d rd %0d expected wr %0d rd %0d", r, k, wr_cnt[r][k], rd_cnt[r][k], ew, er);
                end
            end
    endtask

    task automatic test_stall();
        build_run(rw(), 0, 1, 5, 3, 0, 1'b0, 1'b0, -1, -1);
        run_queue();
        tests++; if (done_at != 60) begin fails++; $display("FAIL stall_done_cycle: got %0d expected 60", done_at); end
        tests++; if (n_set_ifm != 45) begin fails++; $display("FAIL stall_set_ifm: got %0d expected 45", n_set_ifm); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        build_run(rw(), 0, -1, -1, 0, 0, 1'b0, 1'b1, 2, 4);
        run_queue();
        rst_n = 1'b0;
        @(posedge clk1); #1;
        tests++;
        if (actual() !== obs_t'(0) || ifm_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: got %h ready %b expected all zero", actual(), ifm_ready);
        end
        rst_n = 1'b1;
        m = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            ifm_valid = rb(); wgt_valid = rb();
            @(posedge clk1); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        ifm_valid = 1'b0; wgt_valid = 1'b0;
        tests++; if (seen != 0) begin fails++; $display("FAIL midrun_quiet: got %0d active cycles expected 0", seen); end
        build_run(rw(), 0, -1, -1, 0, 0, 1'b0, 1'b0, -1, -1);
        run_queue();
        tests++; if (done_at != 57) begin fails++; $display("FAIL restart_done_cycle: got %0d expected 57", done_at); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] w;
        w = 72'h010203010203010203;
        build_run(w, 0, -1, -1, 0, 0, 1'b1, 1'b0, -1, -1);
        run_queue();
        tests++; if (n_done != 1) begin fails++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done); end
        build_run(w, 0, -1, -1, 0, 0, 1'b0, 1'b0, -1, -1);
        run_queue();
        tests++;
        if (done_at != 57 || n_set_ifm != 45 || n_wr_clr != 5 || n_rd_clr != 5) begin
            fails++;
            $display("FAIL second_run: done %0d set_ifm %0d wr_clr %0d rd_clr %0d expected 57 45 5 5", done_at, n_set_ifm, n_wr_clr, n_rd_clr);
        end
    endtask

    task automatic test_random_runs();
        for (int n = 0; n < 3; n++) begin
            build_run(rw(), int'($urandom_range(0, 3)), -1, -1, 0, 25, 1'b1, 1'b1, -1, -1);
            run_queue();
            tests++;
            if (n_done != 1 || n_set_ifm != 45) begin
                fails++;
                $display("FAIL random_run %0d: done %0d set_ifm %0d expected 1 45", n, n_done, n_set_ifm);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '0;
        test_reset();
        test_full_run();
        test_row0();
        test_row_rules();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_random_runs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
